// File: rtl/universal_gate_sweeper.sv
// Sweeps a NAND/NOR gate through {a,b}=0..3, samples after SETTLE_CYCLES and records per-vector mismatches.
// Each vector takes SETTLE_CYCLES+2 cycles; start is ignored while busy or in DONE.
module universal_gate_sweeper #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       ynand_in,
  input  logic       ynor_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] nand_fail_mask,
  output logic [3:0] nor_fail_mask,
  output logic [2:0] err_count,
  output logic [1:0] vec_idx
);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             nand_bad;
  logic             nor_bad;
  logic [3:0]       nand_mask_nxt;
  logic [3:0]       nor_mask_nxt;
  logic [1:0]       vec_nxt;

  always_comb begin
    nand_bad      = ynand_in != ~(a_out & b_out);
    nor_bad       = ynor_in  != ~(a_out | b_out);
    nand_mask_nxt = nand_fail_mask | (4'(nand_bad) << vec_idx);
    nor_mask_nxt  = nor_fail_mask  | (4'(nor_bad)  << vec_idx);
    vec_nxt       = vec_idx + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      a_out          <= 1'b0;
      b_out          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      nand_fail_mask <= 4'b0000;
      nor_fail_mask  <= 4'b0000;
      err_count      <= 3'd0;
      vec_idx        <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_APPLY;
            nand_fail_mask <= 4'b0000;
            nor_fail_mask  <= 4'b0000;
            err_count      <= 3'd0;
            pass           <= 1'b0;
            vec_idx        <= 2'd0;
            a_out          <= 1'b0;
            b_out          <= 1'b0;
            busy           <= 1'b1;
          end
        end
        S_APPLY: begin
          cnt   <= CNT_W'(SETTLE_CYCLES);
          state <= (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
        end
        S_SETTLE: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          nand_fail_mask <= nand_mask_nxt;
          nor_fail_mask  <= nor_mask_nxt;
          if (nand_bad || nor_bad) err_count <= err_count + 3'd1;
          if (vec_idx == 2'd3) begin
            // pass must see this vector's result, so it uses the next-state masks
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (nand_mask_nxt == 4'b0000) && (nor_mask_nxt == 4'b0000);
          end else begin
            vec_idx <= vec_nxt;
            a_out   <= vec_nxt[1];
            b_out   <= vec_nxt[0];
            state   <= S_APPLY;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_universal_gate_sweeper.sv
// Bench: two sweepers (settle 2 and settle 0) against a table-driven gate model and a per-vector reference.
module tb_universal_gate_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic start2 = 1'b0, start0 = 1'b0;
  logic ynand_g, ynor_g;
  logic a2, b2, busy2, done2, pass2, a0, b0, busy0, done0, pass0;
  logic [3:0] nm2, rm2, nm0, rm0;
  logic [2:0] ec2, ec0;
  logic [1:0] vi2, vi0;

  universal_gate_sweeper #(.SETTLE_CYCLES(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2),
    .ynand_in(ynand_g), .ynor_in(ynor_g), .busy(busy2), .done(done2), .pass(pass2),
    .nand_fail_mask(nm2), .nor_fail_mask(rm2), .err_count(ec2), .vec_idx(vi2));

  universal_gate_sweeper #(.SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_out(a0), .b_out(b0),
    .ynand_in(ynand_g), .ynor_in(ynor_g), .busy(busy0), .done(done0), .pass(pass0),
    .nand_fail_mask(nm0), .nor_fail_mask(rm0), .err_count(ec0), .vec_idx(vi0));

  int cur_s = 2;
  int n_cmp = 0, n_err = 0;
  logic [3:0] resp_nand = 4'b0111, resp_nor = 4'b0001;
  logic glitch_en = 1'b0, is_samp = 1'b0, gl_n = 1'b0, gl_r = 1'b0;

  logic o_a, o_b, o_busy, o_done, o_pass;
  logic [3:0] o_nm, o_rm;
  logic [2:0] o_ec;
  logic [1:0] o_vi, gidx;

  always_comb begin
    if (cur_s == 0) begin
      {o_a, o_b, o_busy, o_done, o_pass} = {a0, b0, busy0, done0, pass0};
      {o_nm, o_rm, o_ec, o_vi} = {nm0, rm0, ec0, vi0};
    end else begin
      {o_a, o_b, o_busy, o_done, o_pass} = {a2, b2, busy2, done2, pass2};
      {o_nm, o_rm, o_ec, o_vi} = {nm2, rm2, ec2, vi2};
    end
    gidx    = {o_a, o_b};
    ynand_g = (glitch_en && !is_samp) ? gl_n : resp_nand[gidx];
    ynor_g  = (glitch_en && !is_samp) ? gl_r : resp_nor[gidx];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (cur_s == 0) start0 = v;
    else start2 = v;
  endtask

  // Reference: compare each table entry against the ideal NAND/NOR truth table.
  task automatic model(output logic [3:0] enm, output logic [3:0] erm, output logic [2:0] eec);
    enm = '0; erm = '0; eec = '0;
    for (int k = 0; k < 4; k++) begin
      logic a, b, bad_n, bad_r;
      a = ((k >> 1) & 1) == 1;
      b = (k & 1) == 1;
      bad_n = resp_nand[k] != !(a && b);
      bad_r = resp_nor[k]  != !(a || b);
      enm[k] = bad_n;
      erm[k] = bad_r;
      if (bad_n || bad_r) eec = eec + 3'd1;
    end
  endtask

  task automatic sweep(input int s, input logic [3:0] rn, input logic [3:0] rr,
                       input logic gl, input int extra_at, input string tag);
    int per, dcyc;
    logic [3:0] enm, erm;
    logic [2:0] eec;
    per = s + 2;
    dcyc = 4 * per + 1;
    cur_s = s; resp_nand = rn; resp_nor = rr; glitch_en = gl; is_samp = 1'b0;
    model(enm, erm, eec);
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    for (int c = 1; c <= dcyc + 2; c++) begin
      @(negedge clk);
      set_start(c == extra_at);
      is_samp = (c % per == 0) && (c <= 4 * per);
      gl_n = 1'($urandom);
      gl_r = 1'($urandom);
      if (c <= 4 * per) begin
        chk({tag, "_vec"}, 32'(o_vi), 32'((c - 1) / per));
        chk({tag, "_ab"}, 32'({o_a, o_b}), 32'((c - 1) / per));
        chk({tag, "_busy"}, 32'(o_busy), 32'd1);
      end else begin
        chk({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_hold_ab"}, 32'({o_a, o_b}), 32'd3);
      end
      chk({tag, "_done"}, 32'(o_done), 32'(c == dcyc));
      if (c >= dcyc) begin
        chk({tag, "_nmask"}, 32'(o_nm), 32'(enm));
        chk({tag, "_rmask"}, 32'(o_rm), 32'(erm));
        chk({tag, "_errcnt"}, 32'(o_ec), 32'(eec));
        chk({tag, "_pass"}, 32'(o_pass), 32'(eec == 3'd0));
      end
    end
    set_start(1'b0);
    glitch_en = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst2", {a2, b2, busy2, done2, pass2, nm2, rm2, ec2, vi2}, 32'd0);
    chk("rst0", {a0, b0, busy0, done0, pass0, nm0, rm0, ec0, vi0}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    sweep(2, 4'b0111, 4'b0001, 1'b0, 0, "good2");
    sweep(2, 4'b0000, 4'b0001, 1'b0, 0, "nand_sa0");
    sweep(2, 4'b0001, 4'b0111, 1'b1, 0, "swapped");
    sweep(0, 4'b0111, 4'b0001, 1'b0, 4, "good0_restart");
    sweep(0, 4'b0111, 4'b0001, 1'b0, 9, "good0_start_in_done");

    // abort during the settle of vector 2 (cycle 10 with settle 2)
    cur_s = 2; resp_nand = 4'b0000; resp_nor = 4'b0001;
    @(negedge clk); set_start(1'b1);
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      set_start(1'b0);
    end
    chk("pre_rst_busy", 32'(busy2), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {a2, b2, busy2, done2, pass2, nm2, rm2, ec2, vi2}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("post_rst_done", 32'({done2, busy2}), 32'd0);
    end
    sweep(2, 4'b0111, 4'b0001, 1'b0, 0, "after_rst");

    // start held for 40 cycles: sweeps accepted at E0 and after each DONE
    cur_s = 2; resp_nand = 4'b0111; resp_nor = 4'b0001;
    @(negedge clk); set_start(1'b1);
    @(posedge clk);
    for (int c = 1; c <= 56; c++) begin
      @(negedge clk);
      set_start(c <= 39);
      chk("hold_done", 32'(done2), 32'(c == 17 || c == 35 || c == 53));
      if (c == 17 || c == 35 || c == 53) chk("hold_pass", 32'(pass2), 32'd1);
    end

    for (int i = 0; i < 8; i++) begin
      int s, ex, gap;
      logic [3:0] rn, rr;
      s = ($urandom_range(0, 1) == 0) ? 0 : 2;
      if ($urandom_range(0, 1) == 0) begin
        rn = 4'b0111; rr = 4'b0001;
      end else begin
        rn = 4'($urandom); rr = 4'($urandom);
      end
      ex = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4 * (s + 2) + 1);
      sweep(s, rn, rr, 1'($urandom), ex, "rand");
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/universal_gate_sweeper.md
Name: universal_gate_sweeper

Overview:
- Self-checking stimulus/capture stage wrapped around the universal NAND/NOR gate block.
- Upstream role: on a start request it drives the gate's inputs a and b through all four input combinations.
- Downstream role: after a programmable settle time it samples the gate's ynand/ynor outputs and compares them to the expected values.
- Reports per-vector mismatch masks, an error count and a single-cycle done pulse with a pass flag.

Parameters:
- SETTLE_CYCLES, 2, idle cycles between applying a vector and sampling the outputs; legal range 0..15.
- CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a sweep; sampled only in IDLE.
- a_out  output  1  drives gate input a (registered).
- b_out  output  1  drives gate input b (registered).
- ynand_in  input  1  gate NAND output under test.
- ynor_in  input  1  gate NOR output under test.
- busy  output  1  high from the APPLY of vector 0 through the last SAMPLE.
- done  output  1  one-cycle pulse when the sweep completes.
- pass  output  1  1 when both fail masks are zero; valid from done, held until the next accepted start.
- nand_fail_mask  output  4  bit k set if ynand mismatched on vector k.
- nor_fail_mask  output  4  bit k set if ynor mismatched on vector k.
- err_count  output  3  number of vectors with any mismatch (0..4).
- vec_idx  output  2  index of the vector currently applied.

Behaviour:
- Reset (rst_n=0, async) forces all outputs to 0: a_out, b_out, busy, done, pass, both masks, err_count, vec_idx. State goes to IDLE and the settle counter to 0.
- Vector encoding: vector k = {a,b}, so a_out = vec_idx[1] and b_out = vec_idx[0]. Order is 0,1,2,3.
- Expected values: ynand = ~(a&b), ynor = ~(a|b).
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 at an edge: clear masks, err_count and pass; set vec_idx=0 and drive a_out/b_out from it; go to APPLY.
  - start=0: stay in IDLE. Outputs hold their last sweep result.
- APPLY (1 cycle): load the settle counter with SETTLE_CYCLES. Go to SETTLE if SETTLE_CYCLES>0, else go directly to SAMPLE.
- SETTLE: decrement the counter each cycle; go to SAMPLE on the cycle the counter reaches 1. Total SETTLE_CYCLES cycles spent.
- SAMPLE (1 cycle):
  - Compare ynand_in/ynor_in with the expected values for the current a_out/b_out.
  - Set nand_fail_mask[vec_idx] and/or nor_fail_mask[vec_idx] on mismatch.
  - Increment err_count if either output mismatched.
  - If vec_idx==3, go to DONE. Otherwise increment vec_idx, update a_out/b_out on the same edge, and go to APPLY.
- DONE (1 cycle):
  - done=1; pass = (both masks zero) is registered on entry and held afterwards.
  - busy=0 in this cycle. Next state is IDLE.
  - a_out/b_out hold vector 3 until the next start.
- Timing: with start accepted at edge E0, each vector occupies SETTLE_CYCLES+2 cycles. done is high in cycle 4*(SETTLE_CYCLES+2)+1 counted from E0: cycle 17 for the default of 2, cycle 9 for 0.
- start while busy or in DONE is ignored (no restart, no queueing). start held high continuously restarts a sweep on the first IDLE cycle after DONE.
- ynand_in/ynor_in are used only in SAMPLE; glitches in other states have no effect.
- Reset asserted mid-sweep aborts immediately. Partial results are discarded (outputs cleared) and no done pulse is produced.
- err_count saturates naturally at 4; it cannot overflow.

Test Plan:
- Correct gate model, SETTLE_CYCLES=2, start pulse at E0 -> vec_idx steps 0..3, done pulses exactly at cycle 17, pass=1, both masks 4'b0000, err_count=0.
- ynand stuck-at-0 -> nand_fail_mask=4'b0111, nor_fail_mask=4'b0000, err_count=3, pass=0.
- ynand and ynor swapped -> nand_fail_mask=4'b0110, nor_fail_mask=4'b0110, err_count=2, pass=0.
- SETTLE_CYCLES=0 -> each vector lasts 2 cycles, done at cycle 9; a second start pulse during busy causes no restart and exactly one done pulse.
- Reset asserted during SETTLE of vector 2 -> all outputs 0 immediately, state IDLE, no done. A fresh start then completes a normal sweep with pass=1.
- start held high for 40 cycles, correct gate, SETTLE_CYCLES=2 -> back-to-back sweeps with done at cycles 17 and 35, pass=1 each time.
